// File: rtl/tcm_arb_pkg.sv
// Shared types and helpers for the TCM port arbiter: grant encoding,
// tag width and the address window check.
package tcm_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  localparam int TAG_W = 11;

  // Unsigned subtract makes addresses below the base wrap to large offsets.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [31:0] off;
    off = addr - base;
    return (off < size);
  endfunction

endpackage

// File: rtl/tcm_arb_prio.sv
// Fixed data-over-fetch priority with a bounded data streak so a waiting
// fetch is granted after at most MAX_D_STREAK consecutive data grants.
module tcm_arb_prio
  import tcm_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_req_i,
  input  logic       d_req_i,
  output logic [1:0] gnt_o
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  gnt_e       gnt_s;
  logic [3:0] d_streak_r;
  logic       at_max_s;

  assign at_max_s = (d_streak_r == MAX_STREAK);
  assign gnt_o    = gnt_s;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt_s = GNT_NONE;
    if (rst_i) begin
      gnt_s = GNT_NONE;
    end else if (d_req_i && i_req_i) begin
      if (at_max_s) begin
        gnt_s = GNT_I;
      end else begin
        gnt_s = GNT_D;
      end
    end else if (d_req_i) begin
      gnt_s = GNT_D;
    end else if (i_req_i) begin
      gnt_s = GNT_I;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Count data grants only while a fetch is waiting behind them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_streak_r <= 4'd0;
    end else if (!i_req_i || (gnt_s == GNT_I)) begin
      d_streak_r <= 4'd0;
    end else if ((gnt_s == GNT_D) && !at_max_s) begin
      d_streak_r <= d_streak_r + 4'd1;
    end else begin
      d_streak_r <= d_streak_r;
    end
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Shares one single-ported TCM SRAM between the core fetch and data ports;
// one access per cycle, responses registered one cycle after the grant.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          SIZE_BYTES   = 131072,
  parameter int          AW           = $clog2(SIZE_BYTES / 4),
  parameter int          MAX_D_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_i_rd_i,
  input  logic              mem_i_flush_i,
  input  logic              mem_i_invalidate_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [31:0]       mem_i_inst_o,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_flush_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam logic [31:0] SIZE = 32'(SIZE_BYTES);

  logic [1:0]       gnt_s;
  logic             d_wr_s;
  logic             d_rd_s;
  logic             d_maint_s;
  logic             d_req_s;
  logic [31:0]      d_off_s;
  logic [31:0]      i_off_s;
  logic             d_inr_s;
  logic             i_inr_s;
  logic             i_acc_s;
  logic             d_acc_s;
  logic             ram_en_s;
  logic [3:0]       ram_we_s;
  logic [AW-1:0]    ram_addr_s;
  logic [31:0]      ram_wdata_s;
  logic             i_vld_r;
  logic             i_err_r;
  logic             d_ack_r;
  logic             d_err_r;
  logic             d_rd_r;
  logic [TAG_W-1:0] d_tag_r;
  logic             unused_s;

  // A strobed access is a write even if the read line is also set.
  assign d_wr_s    = |mem_d_wr_i;
  assign d_rd_s    = mem_d_rd_i & ~d_wr_s;
  assign d_maint_s = ~mem_d_rd_i & ~d_wr_s;
  assign d_req_s   = mem_d_rd_i | d_wr_s | mem_d_flush_i | mem_d_invalidate_i;

  assign d_off_s = mem_d_addr_i - BASE_ADDR;
  assign i_off_s = mem_i_pc_i - BASE_ADDR;
  assign d_inr_s = addr_in_range(mem_d_addr_i, BASE_ADDR, SIZE);
  assign i_inr_s = addr_in_range(mem_i_pc_i, BASE_ADDR, SIZE);

  assign unused_s = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                      d_off_s[31:AW+2], d_off_s[1:0],
                      i_off_s[31:AW+2], i_off_s[1:0]};

  tcm_arb_prio #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_prio (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_req_i(mem_i_rd_i),
    .d_req_i(d_req_s),
    .gnt_o  (gnt_s)
  );

  // SRAM drive for the granted port; maintenance and out-of-range skip the RAM.
  always_comb begin
    i_acc_s     = 1'b0;
    d_acc_s     = 1'b0;
    ram_en_s    = 1'b0;
    ram_we_s    = 4'b0000;
    ram_addr_s  = {AW{1'b0}};
    ram_wdata_s = 32'h0000_0000;
    case (gnt_s)
      GNT_I: begin
        i_acc_s = 1'b1;
        if (i_inr_s) begin
          ram_en_s   = 1'b1;
          ram_addr_s = i_off_s[AW+1:2];
        end else begin
          ram_en_s   = 1'b0;
        end
      end
      GNT_D: begin
        d_acc_s = 1'b1;
        if (!d_maint_s && d_inr_s) begin
          ram_en_s   = 1'b1;
          ram_addr_s = d_off_s[AW+1:2];
          if (d_wr_s) begin
            ram_we_s    = mem_d_wr_i;
            ram_wdata_s = mem_d_data_wr_i;
          end else begin
            ram_we_s    = 4'b0000;
          end
        end else begin
          ram_en_s = 1'b0;
        end
      end
      default: begin
        ram_en_s = 1'b0;
      end
    endcase
  end

  // Response pipes: capture what the granted access needs one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_vld_r <= 1'b0;
      i_err_r <= 1'b0;
      d_ack_r <= 1'b0;
      d_err_r <= 1'b0;
      d_rd_r  <= 1'b0;
      d_tag_r <= {TAG_W{1'b0}};
    end else begin
      i_vld_r <= (gnt_s == GNT_I);
      i_err_r <= (gnt_s == GNT_I) && !i_inr_s;
      d_ack_r <= (gnt_s == GNT_D);
      d_err_r <= (gnt_s == GNT_D) && !d_maint_s && !d_inr_s;
      d_rd_r  <= (gnt_s == GNT_D) && d_rd_s && d_inr_s;
      d_tag_r <= (gnt_s == GNT_D) ? mem_d_req_tag_i : {TAG_W{1'b0}};
    end
  end

  assign mem_i_accept_o = i_acc_s;
  assign mem_d_accept_o = d_acc_s;
  assign ram_en_o       = ram_en_s;
  assign ram_we_o       = ram_we_s;
  assign ram_addr_o     = ram_addr_s;
  assign ram_wdata_o    = ram_wdata_s;

  // Gating with rst_i drops a response whose grant preceded a reset.
  assign mem_i_valid_o    = i_vld_r & ~rst_i;
  assign mem_i_error_o    = i_err_r & ~rst_i;
  assign mem_i_inst_o     = (i_vld_r & ~i_err_r & ~rst_i) ? ram_rdata_i : 32'h0000_0000;
  assign mem_d_ack_o      = d_ack_r & ~rst_i;
  assign mem_d_error_o    = d_err_r & ~rst_i;
  assign mem_d_data_rd_o  = (d_rd_r & ~rst_i) ? ram_rdata_i : 32'h0000_0000;
  assign mem_d_resp_tag_o = rst_i ? {TAG_W{1'b0}} : d_tag_r;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Scoreboard bench for tcm_port_arbiter with a behavioural SRAM behind it.
module tb_tcm_port_arbiter;

  localparam int AW = 15;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        i_rd, i_flush, i_inval;
  logic [31:0] i_pc;
  logic        i_accept, i_valid, i_error;
  logic [31:0] i_inst;
  logic [31:0] d_addr, d_wdata;
  logic        d_rd;
  logic [3:0]  d_wr;
  logic        d_cache;
  logic [10:0] d_tag;
  logic        d_inval, d_flush;
  logic        d_accept, d_ack, d_error;
  logic [31:0] d_rdata;
  logic [10:0] d_rtag;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] sram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct packed {
    logic        i_v;
    logic        i_e;
    logic [31:0] i_d;
    logic        d_v;
    logic        d_e;
    logic [31:0] d_d;
    logic [10:0] tag;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_streak = 0;
  int    cyc = 0;

  tcm_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inval),
    .mem_i_pc_i(i_pc), .mem_i_accept_o(i_accept), .mem_i_valid_o(i_valid),
    .mem_i_error_o(i_error), .mem_i_inst_o(i_inst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd),
    .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag),
    .mem_d_invalidate_i(d_inval), .mem_d_flush_i(d_flush),
    .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack), .mem_d_error_o(d_error),
    .mem_d_data_rd_o(d_rdata), .mem_d_resp_tag_o(d_rtag),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM, read data valid the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= sram[ram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // One cycle: drive, check same-cycle grant/RAM drive, then check the response.
  task automatic drive_cycle(input logic irq, input logic [31:0] pc,
                             input logic drd, input logic [3:0] dwr, input logic dfl,
                             input logic [31:0] daddr, input logic [31:0] dwd,
                             input logic [10:0] tag, output logic gi, output logic gd);
    logic [31:0] ioff, doff;
    logic iinr, dinr, dreq, dwrite, dread, dmaint, en;
    logic [AW-1:0] iw, dw;
    resp_t r, got;
    i_rd = irq; i_pc = pc; d_rd = drd; d_wr = dwr; d_flush = dfl;
    d_addr = daddr; d_wdata = dwd; d_tag = tag;
    #1;
    ioff = pc - BASE;    iinr = (ioff < 32'd131072); iw = ioff[AW+1:2];
    doff = daddr - BASE; dinr = (doff < 32'd131072); dw = doff[AW+1:2];
    dwrite = (dwr != 4'b0000);
    dread  = drd && !dwrite;
    dmaint = !drd && !dwrite;
    dreq   = drd || dwrite || dfl;
    if (dreq && irq) begin gd = (m_streak != 4); gi = !gd; end
    else begin gd = dreq; gi = irq; end
    en = (gi && iinr) || (gd && !dmaint && dinr);
    check_val("i_accept", {31'd0, i_accept}, {31'd0, gi});
    check_val("d_accept", {31'd0, d_accept}, {31'd0, gd});
    check_val("ram_en", {31'd0, ram_en}, {31'd0, en});
    if (en) begin
      check_val("ram_addr", {17'd0, ram_addr}, {17'd0, (gi ? iw : dw)});
      check_val("ram_we", {28'd0, ram_we}, {28'd0, ((gd && dwrite) ? dwr : 4'b0000)});
      if (gd && dwrite) check_val("ram_wdata", ram_wdata, dwd);
    end
    r.i_v = gi;
    r.i_e = gi && !iinr;
    r.i_d = (gi && iinr) ? ref_mem[iw] : 32'h0;
    r.d_v = gd;
    r.d_e = gd && !dmaint && !dinr;
    r.d_d = (gd && dread && dinr) ? ref_mem[dw] : 32'h0;
    r.tag = gd ? tag : 11'h000;
    exp_q.push_back(r);
    if (gd && dwrite && dinr)
      for (int b = 0; b < 4; b++)
        if (dwr[b]) ref_mem[dw][8*b +: 8] = dwd[8*b +: 8];
    if (!irq || gi) m_streak = 0;
    else if (gd && m_streak < 4) m_streak++;
    @(posedge clk);
    #1;
    r = exp_q.pop_front();
    got.i_v = i_valid; got.i_e = i_error; got.i_d = i_inst;
    got.d_v = d_ack; got.d_e = d_error; got.d_d = d_rdata; got.tag = d_rtag;
    check_val("i_valid", {31'd0, got.i_v}, {31'd0, r.i_v});
    check_val("i_error", {31'd0, got.i_e}, {31'd0, r.i_e});
    check_val("i_inst", got.i_d, r.i_d);
    check_val("d_ack", {31'd0, got.d_v}, {31'd0, r.d_v});
    check_val("d_error", {31'd0, got.d_e}, {31'd0, r.d_e});
    check_val("d_rdata", got.d_d, r.d_d);
    check_val("d_rtag", {21'd0, got.tag}, {21'd0, r.tag});
  endtask

  task automatic idle();
    logic gi, gd;
    drive_cycle(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h000, gi, gd);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_outs"},
              {24'd0, i_accept, i_valid, i_error, d_accept, d_ack, d_error, ram_en, |ram_we},
              32'h0);
    check_val({tag, "_data"}, i_inst | d_rdata | {21'd0, d_rtag}, 32'h0);
  endtask

  initial begin
    logic gi, gd;
    int wait_cnt, max_wait;
    clk = 1'b0; rst = 1'b1;
    i_rd = 1'b0; i_flush = 1'b0; i_inval = 1'b0; i_pc = 32'h0;
    d_addr = 32'h0; d_wdata = 32'h0; d_rd = 1'b0; d_wr = 4'b0000;
    d_cache = 1'b0; d_tag = 11'h000; d_inval = 1'b0; d_flush = 1'b0;
    for (int k = 0; k < (1 << AW); k++) begin
      sram[k] = 32'h0; ref_mem[k] = 32'h0;
    end
    sram[4] = 32'h0000_0013; ref_mem[4] = 32'h0000_0013;
    ram_rdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    i_rd = 1'b1; d_rd = 1'b1; i_pc = 32'h8000_0010; d_addr = 32'h8000_0100;
    #1;
    check_quiet("reset_req");
    i_rd = 1'b0; d_rd = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Fetch of word 4.
    drive_cycle(1'b1, 32'h8000_0010, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h000, gi, gd);
    idle();

    // Clear, half-word write, read back.
    drive_cycle(1'b0, 32'h0, 1'b0, 4'b1111, 1'b0, 32'h8000_0100, 32'h0, 11'd4, gi, gd);
    drive_cycle(1'b0, 32'h0, 1'b0, 4'b0011, 1'b0, 32'h8000_0100, 32'hAABB_CCDD, 11'd5, gi, gd);
    drive_cycle(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h8000_0100, 32'h0, 11'd6, gi, gd);
    check_val("rd_merge", ref_mem[32'h40], 32'h0000_CCDD);
    // Read and write together count as a write.
    drive_cycle(1'b0, 32'h0, 1'b1, 4'b1100, 1'b0, 32'h8000_0100, 32'h1122_3344, 11'd7, gi, gd);
    idle();

    // Both ports held: D,D,D,D,I.
    max_wait = 0; wait_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      drive_cycle(1'b1, 32'h8000_0010, 1'b1, 4'b0000, 1'b0, 32'h8000_0100, 32'h0, 11'(k), gi, gd);
      check_val("starve_pat", {31'd0, gi}, {31'd0, (k % 5 == 4)});
      if (gi) wait_cnt = 0; else wait_cnt++;
      if (wait_cnt > max_wait) max_wait = wait_cnt;
    end
    check_val("max_wait_le4", {31'd0, (max_wait <= 4)}, 32'd1);
    idle();

    // Out of range on both ports; fetch holds until granted.
    drive_cycle(1'b1, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 32'h8002_0000, 32'h0, 11'h055, gi, gd);
    drive_cycle(1'b1, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h000, gi, gd);
    drive_cycle(1'b0, 32'h0, 1'b0, 4'b1111, 1'b0, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 11'h0AA, gi, gd);

    // Flush never touches RAM nor errors, even out of range.
    drive_cycle(1'b0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h0000_0000, 32'h0, 11'h7FF, gi, gd);
    drive_cycle(1'b0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h8000_0020, 32'h0, 11'h123, gi, gd);
    idle();

    // Randomised traffic against the model.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] pa, da;
      logic [3:0]  wr;
      pa = BASE + ($urandom_range(0, 31) << 2);
      da = BASE + ($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 7) == 0) pa = $urandom;
      if ($urandom_range(0, 7) == 0) da = $urandom;
      wr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      drive_cycle(1'($urandom), pa, 1'($urandom), wr, ($urandom_range(0, 9) == 0),
                  da, $urandom, 11'($urandom), gi, gd);
    end
    idle();

    // Reset in the cycle after a grant drops its response.
    d_rd = 1'b1; d_addr = 32'h8000_0100; d_tag = 11'd3;
    #1;
    check_val("rst_gnt_acc", {31'd0, d_accept}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1; d_rd = 1'b0;
    #1;
    check_quiet("rst_drop");
    i_rd = 1'b1; d_rd = 1'b1;
    #1;
    check_quiet("rst_hold");
    @(posedge clk);
    #1;
    check_quiet("rst_hold2");
    i_rd = 1'b0; d_rd = 1'b0; rst = 1'b0; m_streak = 0;
    @(posedge clk);
    #1;
    check_quiet("rst_after");
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcm_port_arbiter.md
Name: tcm_port_arbiter

Overview:
- Shares one single-ported, 32-bit-wide TCM SRAM between the core instruction-fetch port (mem_i_*) and data port (mem_d_*).
- Sits between riscv_core and the SRAM macro and replaces the dual-ported behavioural TCM used in the vector bench.
- Grants at most one access per cycle, range-checks addresses, and returns responses one cycle after grant.
- Data has priority over fetch, bounded by an anti-starvation counter.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of TCM word 0.
- SIZE_BYTES, 131072, TCM size; power of two, at least 8.
- AW, $clog2(SIZE_BYTES/4), SRAM word-address width (15 at default).
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is waiting; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- mem_i_rd_i  in  1  fetch request
- mem_i_flush_i  in  1  ignored (no I-cache)
- mem_i_invalidate_i  in  1  ignored
- mem_i_pc_i  in  32  fetch byte address; bits [1:0] ignored
- mem_i_accept_o  out  1  fetch granted this cycle
- mem_i_valid_o  out  1  fetch response pulse
- mem_i_error_o  out  1  fetch out of range
- mem_i_inst_o  out  32  fetched word
- mem_d_addr_i  in  32  data byte address; bits [1:0] ignored
- mem_d_data_wr_i  in  32  write data
- mem_d_rd_i  in  1  read request
- mem_d_wr_i  in  4  byte write strobes
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag
- mem_d_invalidate_i  in  1  maintenance request (no RAM access)
- mem_d_flush_i  in  1  maintenance request (no RAM access)
- mem_d_accept_o  out  1  data request granted this cycle
- mem_d_ack_o  out  1  data response pulse
- mem_d_error_o  out  1  data out of range
- mem_d_data_rd_o  out  32  read data
- mem_d_resp_tag_o  out  11  echoed tag
- ram_en_o  out  1  SRAM access strobe
- ram_we_o  out  4  SRAM byte write enables
- ram_addr_o  out  AW  SRAM word address
- ram_wdata_o  out  32  SRAM write data
- ram_rdata_i  in  32  SRAM read data; valid the cycle after ram_en_o

Behaviour:
- Request classes:
  - d_req = mem_d_rd_i | (mem_d_wr_i != 0) | mem_d_flush_i | mem_d_invalidate_i.
  - i_req = mem_i_rd_i.
- In range: (addr - BASE_ADDR) < SIZE_BYTES, computed as an unsigned 32-bit subtract. Word address = offset[AW+1:2].
- Grant (combinational, same cycle):
  - Only one requester: it is granted.
  - Both requesting: D is granted unless d_streak == MAX_D_STREAK, in which case I is granted.
  - accept_o is asserted in the cycle of grant only.
  - A requester that is not granted holds its request; its accept_o stays 0.
- d_streak counter:
  - Increments on a D grant while i_req is high.
  - Clears on any I grant, or in any cycle with i_req low.
  - Saturates at MAX_D_STREAK.
- RAM drive:
  - ram_en_o = 1 only for an in-range granted read, write or fetch.
  - Flush/invalidate and out-of-range accesses do not touch the SRAM.
  - D request with both mem_d_rd_i and write strobes set: treated as a write.
  - ram_we_o equals the D write strobes on writes, else 0.
- Responses: registered, exactly one cycle after grant, single-cycle pulses.
  - I: mem_i_valid_o=1; mem_i_inst_o = ram_rdata_i, or 0 if error; mem_i_error_o = out of range.
  - D: mem_d_ack_o=1; mem_d_resp_tag_o = captured tag.
  - D read: mem_d_data_rd_o = ram_rdata_i.
  - D write or maintenance: mem_d_data_rd_o = 0.
  - D error: mem_d_error_o=1 and data 0. Maintenance requests never error.
  - Data outputs are 0 in non-response cycles.
- Throughput: back-to-back grants every cycle with no bubbles. The I and D response pipes are independent.
- Reset:
  - All outputs 0, d_streak 0, response pipes cleared.
  - Reset asserted the cycle after a grant drops that response; no pulse is emitted.
  - While rst_i is high, accept_o and ram_en_o are forced 0.

Decomposition:
- Package tcm_arb_pkg:
  - grant enum GNT_NONE/GNT_I/GNT_D.
  - Tag width constant (11).
  - Range-check function.
- Sub-module tcm_arb_prio: grant logic and d_streak counter.
- Top level: address decode, SRAM drive, response registers.

Test Plan:
- Fetch only, pc=32'h80000010, RAM word 4 = 32'h00000013 -> accept cycle N; valid=1, inst=32'h00000013 at N+1.
- D write addr=32'h80000100, wr=4'b0011, data=32'hAABBCCDD, tag=5; next cycle read same addr, tag=6 -> write ack at +1 with tag 5, data 0; read ack at +1 with tag 6, data 32'h0000CCDD (after a prior clear to 0).
- I and D both held high for 12 cycles, MAX_D_STREAK=4 -> grant pattern D,D,D,D,I repeating; no fetch waits more than 4 cycles.
- D read addr=32'h80020000 (one past end) and fetch pc=32'h00000000 -> no ram_en_o; ack/valid with error=1, data 0.
- mem_d_flush_i with tag=11'h7FF -> accept, no ram_en_o, ack next cycle with tag 11'h7FF, error=0.
- Grant read in cycle N, rst_i=1 in cycle N+1 -> no ack in N+1 or after; all outputs 0 while reset is held.
